control_unit: RTL

Hardwired, one-step-per-clock sequencer for the 32-bit bus datapath. It generates every datapath control strobe that benches currently drive by hand: fetch (T0–T2), then an opcode-dependent execute sequence (T3–T7). It sits beside `bus` and reads the instruction register contents and the CON flip-flop.

---
 rtl/control_unit.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Hardwired T0-T7 sequencer for the 32-bit bus datapath.
// Fetch in T0-T2, opcode-driven execute in T3-T7, plus a HALT sink.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        PCin,
    output logic        Zlowout,
    output logic        MDRRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin_in,
    output logic        Rout_in,
    output logic        BAout,
    output logic        CONin,
    output logic        RAMwrite,
    output logic [11:0] ALUControl,
    output logic        Run
);

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BRZR = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [11:0] ALU_ADD = 12'h001;
    localparam logic [11:0] ALU_SUB = 12'h002;
    localparam logic [11:0] ALU_AND = 12'h004;
    localparam logic [11:0] ALU_OR  = 12'h008;

    state_t      state;
    logic [4:0]  opcode;
    logic        is_ld;
    logic        is_ldi;
    logic        is_st;
    logic        is_alu_r;
    logic        is_alu_i;
    logic        is_brzr;
    logic        is_jr;
    logic        is_halt;
    logic        is_mem;
    logic        is_long;
    logic [11:0] alu_sel;

    assign opcode   = IR[31:27];
    assign is_ld    = (opcode == OP_LD);
    assign is_ldi   = (opcode == OP_LDI);
    assign is_st    = (opcode == OP_ST);
    assign is_alu_r = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_alu_i = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                      (opcode == OP_ORI);
    assign is_brzr  = (opcode == OP_BRZR);
    assign is_jr    = (opcode == OP_JR);
    assign is_halt  = (opcode == OP_HALT);
    assign is_mem   = is_ld || is_st;
    assign is_long  = is_mem || is_ldi || is_alu_r ||
                      is_alu_i || is_brzr;

    // Address arithmetic for ld/ldi/st always adds the offset.
    always_comb begin
        alu_sel = ALU_ADD;
        case (opcode)
            OP_SUB:           alu_sel = ALU_SUB;
            OP_AND, OP_ANDI:  alu_sel = ALU_AND;
            OP_OR,  OP_ORI:   alu_sel = ALU_OR;
            default:          alu_sel = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= T0;
        end else begin
            case (state)
                T0:   state <= T1;
                T1:   state <= T2;
                T2:   state <= T3;
                T3: begin
                    if (is_halt)      state <= HALT;
                    else if (is_long) state <= T4;
                    else              state <= T0;
                end
                T4:   state <= T5;
                T5:   state <= (is_mem || is_brzr) ? T6 : T0;
                T6:   state <= is_mem ? T7 : T0;
                T7:   state <= T0;
                HALT: state <= HALT;
                default: state <= T0;
            endcase
        end
    end

    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        Zlowout    = 1'b0;
        MDRRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Cout       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin_in     = 1'b0;
        Rout_in    = 1'b0;
        BAout      = 1'b0;
        CONin      = 1'b0;
        RAMwrite   = 1'b0;
        ALUControl = 12'h000;
        Run        = !clr && (state != HALT);
        if (!clr) begin
            case (state)
                T0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    Zin   = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    MDRRead = 1'b1;
                    MDRin   = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                T3: begin
                    unique case (1'b1)
                        is_alu_r, is_alu_i: begin
                            Grb     = 1'b1;
                            Rout_in = 1'b1;
                            Yin     = 1'b1;
                        end
                        is_ldi, is_mem: begin
                            Grb   = 1'b1;
                            BAout = 1'b1;
                            Yin   = 1'b1;
                        end
                        is_brzr: begin
                            Gra     = 1'b1;
                            Rout_in = 1'b1;
                            CONin   = 1'b1;
                        end
                        is_jr: begin
                            Gra     = 1'b1;
                            Rout_in = 1'b1;
                            PCin    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    unique case (1'b1)
                        is_alu_r: begin
                            Grc        = 1'b1;
                            Rout_in    = 1'b1;
                            ALUControl = alu_sel;
                            Zin        = 1'b1;
                        end
                        is_alu_i, is_ldi, is_mem: begin
                            Cout       = 1'b1;
                            ALUControl = alu_sel;
                            Zin        = 1'b1;
                        end
                        is_brzr: begin
                            PCout = 1'b1;
                            Yin   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    unique case (1'b1)
                        is_alu_r, is_alu_i, is_ldi: begin
                            Zlowout = 1'b1;
                            Gra     = 1'b1;
                            Rin_in  = 1'b1;
                        end
                        is_mem: begin
                            Zlowout = 1'b1;
                            MARin   = 1'b1;
                        end
                        is_brzr: begin
                            Cout       = 1'b1;
                            ALUControl = ALU_ADD;
                            Zin        = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    unique case (1'b1)
                        is_ld: begin
                            MDRRead = 1'b1;
                            MDRin   = 1'b1;
                        end
                        // MDRRead low steers the bus into MDR.
                        is_st: begin
                            Gra     = 1'b1;
                            Rout_in = 1'b1;
                            MDRin   = 1'b1;
                        end
                        is_brzr: begin
                            Zlowout = CON;
                            PCin    = CON;
                        end
                        default: ;
                    endcase
                end
                T7: begin
                    unique case (1'b1)
                        is_ld: begin
                            MDRout = 1'b1;
                            Gra    = 1'b1;
                            Rin_in = 1'b1;
                        end
                        is_st: RAMwrite = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
